layer_sequencer: RTL and testbench

//  Inter-layer sequencer between two parallel neuron layers. Captures the NN

---
 rtl/layer_sequencer_pkg.sv | 9 +
 rtl/layer_sequencer.sv | 101 ++++++++++
 tb/tb_layer_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types and defaults for the inter-layer sequencer.
package layer_sequencer_pkg;
  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/layer_sequencer.sv
// Captures a full parallel activation frame and replays it one word per beat,
// index 0 first, into the serial input of the next layer.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = DATA_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    partial_err
);
  localparam int IDX_W = $clog2(NN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [NN*dataWidth-1:0] frame;

  logic all_valid;
  logic partial;
  logic beat;
  logic last_beat;

  function automatic logic [dataWidth-1:0] word_at(input logic [NN*dataWidth-1:0] f,
                                                   input logic [IDX_W-1:0] i);
    return f[i*dataWidth +: dataWidth];
  endfunction

  assign all_valid = &in_valid;
  assign partial   = (|in_valid) && !all_valid;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (idx == LAST_IDX);

  // The frame register is pure data and is simply overwritten on capture.
  always_ff @(posedge clk) begin
    if (all_valid && ((state == IDLE) || last_beat)) begin
      frame <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (partial) begin
        partial_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (all_valid) begin
            state     <= SEND;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= in_data[dataWidth-1:0];
          end
        end
        SEND: begin
          if (last_beat) begin
            frame_done <= 1'b1;
            if (all_valid) begin
              // Back-to-back frame: the new word 0 follows word NN-1 with no gap.
              idx      <= '0;
              out_data <= in_data[dataWidth-1:0];
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            if (beat) begin
              idx      <= idx + 1'b1;
              out_data <= word_at(frame, idx + 1'b1);
            end
            if (all_valid) begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized and directed bench for layer_sequencer against a queue-based
// model of the frames still waiting to be sent.
module tb_layer_sequencer;
  localparam int NN = 10;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NN-1:0]        in_valid;
  logic [NN*DW-1:0]     in_data;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;
  logic                 partial_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_last;
  logic          m_done, m_over, m_perr;

  layer_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .partial_err(partial_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [NN*DW-1:0] seq_frame(input logic [DW-1:0] base);
    logic [NN*DW-1:0] f;
    for (int i = 0; i < NN; i++) f[i*DW +: DW] = base + DW'(i);
    return f;
  endfunction

  function automatic logic [NN*DW-1:0] rand_frame();
    logic [NN*DW-1:0] f;
    for (int i = 0; i < NN; i++) f[i*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  // Model: q holds the words not yet handed over; its head is what out_data shows.
  task automatic model_edge(input logic [NN-1:0] iv, input logic [NN*DW-1:0] d,
                            input logic ord, input logic r);
    logic beat;
    if (r) begin
      q.delete();
      m_last = '0; m_done = 0; m_over = 0; m_perr = 0;
      return;
    end
    beat   = (q.size() > 0) && ord;
    m_done = beat && (q.size() == 1);
    if (iv != '0 && iv != '1) m_perr = 1;
    if (beat) void'(q.pop_front());
    if (iv == '1) begin
      if (q.size() == 0) for (int i = 0; i < NN; i++) q.push_back(d[i*DW +: DW]);
      else m_over = 1;
    end
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic step(input logic [NN-1:0] iv, input logic [NN*DW-1:0] d,
                      input logic ord, input logic r);
    in_valid = iv; in_data = d; out_ready = ord; rst = r;
    @(posedge clk);
    model_edge(iv, d, ord, r);
    #1;
    check("out_valid",   32'(out_valid),   32'(q.size() > 0));
    check("busy",        32'(busy),        32'(q.size() > 0));
    check("out_data",    32'(out_data),    32'(m_last));
    check("frame_done",  32'(frame_done),  32'(m_done));
    check("overrun",     32'(overrun),     32'(m_over));
    check("partial_err", 32'(partial_err), 32'(m_perr));
  endtask

  task automatic idle(input logic ord);
    step('0, rand_frame(), ord, 1'b0);
  endtask

  initial begin
    logic [NN-1:0] iv;
    bit done;
    in_valid = '0; in_data = '0; out_ready = 1'b1; rst = 1'b1;
    m_last = '0; m_done = 0; m_over = 0; m_perr = 0;

    step('0, '0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b1);

    // Single frame, downstream always ready.
    step('1, seq_frame(16'h0100), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Same frame with out_ready toggling.
    step('1, seq_frame(16'h0100), 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) idle(i % 2 == 1);

    // Back-to-back frame arriving with the final beat.
    step('1, seq_frame(16'h0200), 1'b1, 1'b0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (q.size() == 1) begin
        step('1, seq_frame(16'h0300), 1'b1, 1'b0);
        done = 1;
      end else idle(1'b1);
    end
    check("b2b_taken", 32'(done), 32'd1);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Second frame mid-stream is dropped and flagged.
    step('1, seq_frame(16'h0400), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    step('1, seq_frame(16'h0500), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // Partial valid only.
    step(10'b0000000011, rand_frame(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset mid-frame, then a fresh frame.
    step('1, seq_frame(16'h0600), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    step('0, '0, 1'b1, 1'b1);
    step('1, seq_frame(16'h0700), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) idle(1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 12)      iv = '1;
      else if (sel < 16) iv = NN'($urandom);
      else               iv = '0;
      step(iv, rand_frame(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
